instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Owns PC and instruction register (IR); fetches one 16-bit instruction per request.
//   Sits directly upstream of control_unit: control_unit pulses fetch_start in STATE_FETCH,
//   then decodes instr[3:0] once instr_valid pulses. Talks to instruction memory over a
//   req/ready + rvalid handshake with variable latency. Applies jump/branch redirects to PC.
// PARAMETERS
//   INSTRUCTION_WIDTH  16      IR / imem_rdata width
//   ADDR_WIDTH         16      PC width; word-addressed, one instruction per word
//   RESET_PC           'h0000  PC value after reset
//   TIMEOUT_CYCLES     255     fetch watchdog limit (FETCH_TIMEOUT_EN builds only)
// PORTS
//   clk             in   1                  clock
//   resetn          in   1                  synchronous, active-low reset
//   fetch_start     in   1                  pulse: begin fetch at current PC
//   redirect_valid  in   1                  load PC from redirect_target (JMP/JPR/BRH taken)
//   redirect_target in   ADDR_WIDTH         new PC
//   imem_req        out  1                  memory request valid
//   imem_addr       out  ADDR_WIDTH         request address (= PC)
//   imem_ready      in   1                  memory accepts request this cycle
//   imem_rvalid     in   1                  response data valid
//   imem_rdata      in   INSTRUCTION_WIDTH  response instruction
//   instr           out  INSTRUCTION_WIDTH  IR contents, stable until next completed fetch
//   instr_valid     out  1                  1-cycle pulse: IR updated
//   pc              out  ADDR_WIDTH         current PC
//   pc_plus1        out  ADDR_WIDTH         pc+1 mod 2^ADDR_WIDTH (LINK return address)
//   busy            out  1                  high in S_REQ/S_WAIT
//   fetch_fault     out  1                  sticky watchdog fault (0 when macro off)
// BEHAVIOUR
//   Reset: state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, redirect_pending=0,
//   fetch_fault=0. Reset mid-fetch abandons the transaction; late rvalid ignored in S_IDLE.
//   FSM (fetch_state_t):
//     S_IDLE: fetch_start -> S_REQ. redirect_valid: pc<=redirect_target; if with fetch_start,
//             request uses the new target (imem_addr driven from registered pc in S_REQ).
//     S_REQ:  imem_req=1, imem_addr=pc, held stable until imem_ready; ready -> S_WAIT.
//             imem_rvalid ignored here (memory latency >=1 cycle after accept).
//     S_WAIT: imem_rvalid -> instr<=imem_rdata, -> S_DONE.
//     S_DONE: instr_valid=1 for this one cycle; pc<=redirect_pending ? pending_target : pc+1;
//             redirect_pending<=0; -> S_IDLE.
//   Minimum latency: fetch_start at cycle 0, ready at 1, rvalid at 2 -> instr_valid at 3.
//   fetch_start while busy or in S_DONE: ignored, not queued.
//   redirect_valid while busy/S_DONE: latched into pending (last one wins); the in-flight
//   instruction is still delivered; PC takes target at S_DONE instead of increment.
//   Redirect at S_DONE same cycle: new target wins over older pending target.
//   PC arithmetic wraps: pc='hFFFF -> pc+1='h0000 (ADDR_WIDTH=16).
// CONFIGURATION
//   `FETCH_TIMEOUT_EN defined: counter runs in S_REQ/S_WAIT; reaching TIMEOUT_CYCLES ->
//     fetch_fault<=1 (sticky until reset), -> S_IDLE, pc unchanged, no instr_valid,
//     pending redirect applied. Counter clears on entering S_REQ.
//   Not defined: no counter; fetch_fault tied 0; fetch waits indefinitely.
// STRUCTURE
//   defs_pkg: fetch_state_t enum (S_IDLE,S_REQ,S_WAIT,S_DONE), RESET_PC default constant.
//   One sub-module: fetch_pc_reg (PC register, +1 adder, redirect/pending select mux).
//   FSM, IR, handshake and watchdog live in instr_fetch_unit.
// TESTING
//   Reset then fetch_start, ready=1 at once, rvalid+rdata='h1234 next cycle -> instr='h1234,
//     instr_valid 1 cycle at cycle 3, pc 0->1.
//   ready held low 4 cycles -> imem_req/imem_addr stable all 4; completes, pc+1 once.
//   redirect_valid target='h0040 during S_WAIT -> in-flight instr delivered, then pc='h0040,
//     next fetch imem_addr='h0040.
//   pc='hFFFF fetch completes -> pc='h0000, pc_plus1='h0001.
//   resetn low in S_WAIT, rvalid arrives after release -> ignored, instr=0, pc=RESET_PC.
//   FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ready -> fetch_fault=1 after 8 cycles, S_IDLE,
//     pc unchanged, no instr_valid; fault stays high until reset.

Source files
------------

// File: rtl/defs_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// defs_pkg : shared fetch FSM state type and reset-PC default
// Rev 1.0
// ----------------------------------------------------------------------------
package defs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_t;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_pc_reg : PC register, +1 incrementer and redirect/pending-target select
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_pc_reg
  import defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  idle_i,
  input  logic                  capture_i,
  input  logic                  complete_i,
  input  logic                  abort_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_target_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus1_o
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] resolved_tgt;

  assign pc_inc       = pc_q + ADDR_WIDTH'(1);
  // A redirect arriving on the closing cycle is newer than any pending one.
  assign resolved_tgt = redirect_valid_i ? redirect_target_i : pend_tgt_q;

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (complete_i || abort_i) begin
      pend_d = 1'b0;
      if (redirect_valid_i || pend_q) begin
        pc_d = resolved_tgt;
      end else if (complete_i) begin
        pc_d = pc_inc;
      end
    end else if (idle_i && redirect_valid_i) begin
      pc_d = redirect_target_i;
    end else if (capture_i && redirect_valid_i) begin
      pend_d     = 1'b1;
      pend_tgt_d = redirect_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus1_o = pc_inc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch_unit : fetch FSM, IR and imem handshake; optional watchdog
//                    enabled by defining FETCH_TIMEOUT_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module instr_fetch_unit
  import defs_pkg::*;
#(
  parameter int                    INSTRUCTION_WIDTH = 16,
  parameter int                    ADDR_WIDTH        = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC          = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         fetch_start,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_target,
  output logic                         imem_req,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic                         instr_valid,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic [ADDR_WIDTH-1:0]        pc_plus1,
  output logic                         busy,
  output logic                         fetch_fault
);

  fetch_state_t                 state_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic                         instr_valid_q;
  logic                         imem_req_q;
  logic                         busy_w;
  logic                         timeout_w;

  assign busy_w = (state_q == S_REQ) || (state_q == S_WAIT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_start) begin
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (timeout_w) begin
            state_q    <= S_IDLE;
            imem_req_q <= 1'b0;
          end else if (imem_ready) begin
            state_q    <= S_WAIT;
            imem_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (timeout_w) begin
            state_q <= S_IDLE;
          end else if (imem_rvalid) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .resetn            (resetn),
    .idle_i            (state_q == S_IDLE),
    .capture_i         (state_q != S_IDLE),
    .complete_i        (state_q == S_DONE),
    .abort_i           (timeout_w),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_o              (pc),
    .pc_plus1_o        (pc_plus1)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             fault_q;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in S_REQ/S_WAIT.
  assign timeout_w = busy_w && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && fetch_start) begin
        wd_cnt_q <= '0;
      end else if (busy_w) begin
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      end
      if (timeout_w) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_w          = 1'b0;
  assign fetch_fault        = 1'b0;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : randomized self-checking bench against a transaction model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fetch_start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        busy;
  logic        fetch_fault;

  instr_fetch_unit #(
    .INSTRUCTION_WIDTH (16),
    .ADDR_WIDTH        (16),
    .RESET_PC          (16'h0000),
    .TIMEOUT_CYCLES    (TB_TIMEOUT)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .fetch_start     (fetch_start),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .pc              (pc),
    .pc_plus1        (pc_plus1),
    .busy            (busy),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] m_pc = 16'h0;
  logic [15:0] exp_next;
  int          r_at = -1;
  logic [15:0] r_tgt = 16'h0;
  bit          rnd_mode = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // Side inputs during a busy/done cycle; the last redirect seen becomes the next PC.
  task automatic side_stim(input int cyc);
    redirect_valid = 1'b0;
    fetch_start    = 1'b0;
    if (cyc == r_at) begin
      redirect_valid  = 1'b1;
      redirect_target = r_tgt;
      exp_next        = r_tgt;
    end
    if (rnd_mode) begin
      fetch_start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        redirect_valid  = 1'b1;
        redirect_target = 16'($urandom);
        exp_next        = redirect_target;
      end
    end
  endtask

  task automatic run_fetch(input int rdy_dly, input int rv_dly, input bit pre_redir,
                           input logic [15:0] pre_tgt);
    logic [15:0] a;
    logic [15:0] d;
    int          cyc;
    a        = pre_redir ? pre_tgt : m_pc;
    d        = mem_word(a);
    exp_next = a + 16'd1;
    fetch_start     = 1'b1;
    redirect_valid  = pre_redir;
    redirect_target = pre_tgt;
    tick();
    cyc = 0;
    for (int i = 0; i <= rdy_dly; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a || busy !== 1'b1) begin
        bad++;
        $display("FAIL req_phase req=%b addr=%h busy=%b expected req=1 addr=%h busy=1",
                 imem_req, imem_addr, busy, a);
      end
      side_stim(cyc);
      imem_ready  = (i == rdy_dly);
      imem_rvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata  = 16'($urandom);
      tick();
      cyc++;
    end
    imem_ready = 1'b0;
    for (int i = 1; i <= rv_dly; i++) begin
      total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL wait_phase req=%b ivalid=%b busy=%b expected 0 0 1",
                 imem_req, instr_valid, busy);
      end
      side_stim(cyc);
      imem_rvalid = (i == rv_dly);
      imem_rdata  = (i == rv_dly) ? d : 16'($urandom);
      tick();
      cyc++;
    end
    imem_rvalid = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || instr !== d || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_phase ivalid=%b instr=%h busy=%b expected 1 %h 0",
               instr_valid, instr, busy, d);
    end
    side_stim(cyc);
    tick();
    redirect_valid = 1'b0;
    fetch_start    = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0 || instr !== d ||
        pc !== exp_next || pc_plus1 !== exp_next + 16'd1) begin
      bad++;
      $display("FAIL after_fetch ivalid=%b busy=%b req=%b instr=%h pc=%h pc1=%h expected 0 0 0 %h %h %h",
               instr_valid, busy, imem_req, instr, pc, pc_plus1, d, exp_next, exp_next + 16'd1);
    end
    m_pc = exp_next;
    r_at = -1;
  endtask

  task automatic idle_redirect(input logic [15:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    tick();
    redirect_valid = 1'b0;
    m_pc = tgt;
    total++;
    if (pc !== tgt || pc_plus1 !== tgt + 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_redirect pc=%h pc1=%h busy=%b expected %h %h 0",
               pc, pc_plus1, busy, tgt, tgt + 16'd1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    m_pc = 16'h0;
    total++;
    if (pc !== 16'h0000 || pc_plus1 !== 16'h0001) begin
      bad++;
      $display("FAIL reset_pc pc=%h pc1=%h expected 0000 0001", pc, pc_plus1);
    end
    total++;
    if (instr !== 16'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || busy !== 1'b0 ||
        fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs instr=%h ivalid=%b req=%b busy=%b fault=%b expected all 0",
               instr, instr_valid, imem_req, busy, fetch_fault);
    end
  endtask

  task automatic test_min_latency();
    mem[16'h0000] = 16'h1234;
    run_fetch(0, 1, 1'b0, 16'h0);
  endtask

  task automatic test_stall();
    run_fetch(4, 2, 1'b0, 16'h0);
  endtask

  task automatic test_redirect_wait();
    r_at  = 1;
    r_tgt = 16'h0040;
    run_fetch(0, 3, 1'b0, 16'h0);
    run_fetch(0, 1, 1'b0, 16'h0);
  endtask

  task automatic test_start_with_redirect();
    run_fetch(1, 2, 1'b1, 16'h0123);
  endtask

  task automatic test_wrap();
    idle_redirect(16'hFFFF);
    run_fetch(1, 1, 1'b0, 16'h0);
  endtask

  task automatic test_reset_midfetch();
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    imem_ready  = 1'b1;
    tick();
    imem_ready = 1'b0;
    resetn     = 1'b0;
    tick();
    resetn      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hBEEF;
    tick();
    imem_rvalid = 1'b0;
    m_pc = 16'h0;
    total++;
    if (instr !== 16'h0 || instr_valid !== 1'b0 || pc !== 16'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_midfetch instr=%h ivalid=%b pc=%h busy=%b expected 0000 0 0000 0",
               instr, instr_valid, pc, busy);
    end
    tick();
    total++;
    if (instr_valid !== 1'b0 || instr !== 16'h0) begin
      bad++;
      $display("FAIL late_rvalid ivalid=%b instr=%h expected 0 0000", instr_valid, instr);
    end
  endtask

  task automatic test_back_to_back();
    rnd_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) idle_redirect(16'($urandom));
      run_fetch(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                1'($urandom_range(0, 1)), 16'($urandom));
    end
    rnd_mode = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
    logic [15:0] start_pc;
    start_pc    = m_pc;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      total++;
      if (fetch_fault !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait i=%0d fault=%b busy=%b ivalid=%b expected 0 1 0",
                 i, fetch_fault, busy, instr_valid);
      end
      tick();
    end
    total++;
    if (fetch_fault !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || pc !== start_pc) begin
      bad++;
      $display("FAIL timeout_fire fault=%b busy=%b ivalid=%b pc=%h expected 1 0 0 %h",
               fetch_fault, busy, instr_valid, pc, start_pc);
    end
    run_fetch(0, 1, 1'b0, 16'h0);
    total++;
    if (fetch_fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_sticky fault=%b expected 1", fetch_fault);
    end
    test_reset();
`else
    run_fetch(20, 5, 1'b0, 16'h0);
    total++;
    if (fetch_fault !== 1'b0) begin
      bad++;
      $display("FAIL no_watchdog fault=%b expected 0", fetch_fault);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_stall();
    test_redirect_wait();
    test_start_with_redirect();
    test_wrap();
    test_reset_midfetch();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
